// File: rtl/intersection_pkg.sv
// Shared definitions for the intersection phase scheduler: light codes,
// phase encoding and green-direction selector.
package intersection_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] GREEN  = 2'b01;
  localparam logic [1:0] YELLOW = 2'b10;

  typedef enum logic [3:0] {
    ALL_RED   = 4'd0,
    NS_GREEN  = 4'd1,
    NS_YELLOW = 4'd2,
    WE_GREEN  = 4'd3,
    WE_YELLOW = 4'd4,
    PED_WALK  = 4'd5,
    POLICE    = 4'd6
  } phase_t;

  typedef enum logic {
    NS = 1'b0,
    WE = 1'b1
  } dir_t;

endpackage

// File: rtl/phase_timer.sv
// Tick-gated dwell counter: clears on request, saturates at limit-1 and
// flags done on the tick that completes the dwell.
module phase_timer #(
  parameter int unsigned TMR_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             clear,
  input  logic [TMR_W-1:0] limit,
  output logic [TMR_W-1:0] value,
  output logic             done
);

  logic [TMR_W-1:0] last;

  assign last = limit - TMR_W'(1);
  assign done = tick && (value == last);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (tick && (value != last)) begin
      value <= value + TMR_W'(1);
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Four-way intersection phase scheduler: arbitrates NS/WE vehicle flows,
// latched pedestrian calls and a police all-red override.
module intersection_phase_scheduler
  import intersection_pkg::*;
#(
  parameter int unsigned GREEN_MIN    = 8,
  parameter int unsigned GREEN_MAX    = 30,
  parameter int unsigned YELLOW_TIME  = 3,
  parameter int unsigned ALL_RED_TIME = 2,
  parameter int unsigned WALK_TIME    = 10,
  parameter int unsigned TMR_W        = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic [3:0] traffic_Street_0,
  input  logic [3:0] traffic_Street_1,
  input  logic       ped_Hori_Interrupt,
  input  logic       ped_Vert_Interrupt,
  input  logic       police_Interrupt,
  output logic [1:0] north_South,
  output logic [1:0] west_East,
  output logic       pedestrian_Hori_Street,
  output logic       pedestrian_Vert_Street,
  output logic [3:0] phase,
  output logic       police_Active
);

  localparam logic [TMR_W-1:0] L_GMIN1  = TMR_W'(GREEN_MIN - 1);
  localparam logic [TMR_W-1:0] L_GMAX1  = TMR_W'(GREEN_MAX - 1);
  localparam logic [TMR_W-1:0] L_GMAX   = TMR_W'(GREEN_MAX);
  localparam logic [TMR_W-1:0] L_YELLOW = TMR_W'(YELLOW_TIME);
  localparam logic [TMR_W-1:0] L_ALLRED = TMR_W'(ALL_RED_TIME);
  localparam logic [TMR_W-1:0] L_WALK   = TMR_W'(WALK_TIME);

  phase_t           state, state_nxt;
  dir_t             next_dir;
  logic             ped_hori_pend, ped_vert_pend, prev_walk;
  logic             ped_pend, leave, enter_walk, t_done, green_exit;
  logic [TMR_W-1:0] timer, limit;
  logic [3:0]       c_own, c_oth;

  phase_timer #(.TMR_W(TMR_W)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (tick),
    .clear   (leave),
    .limit   (limit),
    .value   (timer),
    .done    (t_done)
  );

  assign phase      = state;
  assign ped_pend   = ped_hori_pend || ped_vert_pend;
  assign leave      = (state_nxt != state);
  assign enter_walk = leave && (state_nxt == PED_WALK);
  assign c_own      = (state == WE_GREEN) ? traffic_Street_1 : traffic_Street_0;
  assign c_oth      = (state == WE_GREEN) ? traffic_Street_0 : traffic_Street_1;

  // Early exit once min green is served; forced exit at max green only when someone waits.
  assign green_exit = tick &&
    (((timer >= L_GMIN1) && (ped_pend || (c_oth > c_own))) ||
     ((timer == L_GMAX1) && ((c_oth != '0) || ped_pend)));

  always_comb begin
    limit = TMR_W'(1);
    unique case (state)
      ALL_RED:              limit = L_ALLRED;
      NS_GREEN, WE_GREEN:   limit = L_GMAX;
      NS_YELLOW, WE_YELLOW: limit = L_YELLOW;
      PED_WALK:             limit = L_WALK;
      default:              limit = TMR_W'(1);
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ALL_RED: begin
        if (police_Interrupt)        state_nxt = POLICE;
        else if (t_done) begin
          if (ped_pend && !prev_walk) state_nxt = PED_WALK;
          else if (next_dir == WE)    state_nxt = WE_GREEN;
          else                        state_nxt = NS_GREEN;
        end
      end
      NS_GREEN:  if (police_Interrupt || green_exit) state_nxt = NS_YELLOW;
      WE_GREEN:  if (police_Interrupt || green_exit) state_nxt = WE_YELLOW;
      NS_YELLOW, WE_YELLOW:
        if (t_done) state_nxt = police_Interrupt ? POLICE : ALL_RED;
      PED_WALK: begin
        if (police_Interrupt) state_nxt = POLICE;
        else if (t_done)      state_nxt = ALL_RED;
      end
      POLICE:    if (!police_Interrupt) state_nxt = ALL_RED;
      default:   state_nxt = ALL_RED;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state                  <= ALL_RED;
      next_dir               <= NS;
      ped_hori_pend          <= 1'b0;
      ped_vert_pend          <= 1'b0;
      prev_walk              <= 1'b0;
      north_South            <= RED;
      west_East              <= RED;
      pedestrian_Hori_Street <= 1'b0;
      pedestrian_Vert_Street <= 1'b0;
      police_Active          <= 1'b0;
    end else begin
      state <= state_nxt;
      if (leave) prev_walk <= (state == PED_WALK);
      if (leave && ((state == NS_YELLOW) || (state == WE_YELLOW)))
        next_dir <= (next_dir == NS) ? WE : NS;

      // Calls arriving in the walk-entry cycle survive the clear.
      ped_hori_pend <= (ped_hori_pend && !enter_walk) || ped_Hori_Interrupt;
      ped_vert_pend <= (ped_vert_pend && !enter_walk) || ped_Vert_Interrupt;

      // Walk outputs double as the grant registers captured at walk entry.
      pedestrian_Hori_Street <= (state_nxt == PED_WALK) &&
                                (enter_walk ? ped_hori_pend : pedestrian_Hori_Street);
      pedestrian_Vert_Street <= (state_nxt == PED_WALK) &&
                                (enter_walk ? ped_vert_pend : pedestrian_Vert_Street);

      north_South   <= (state_nxt == NS_GREEN)  ? GREEN :
                       (state_nxt == NS_YELLOW) ? YELLOW : RED;
      west_East     <= (state_nxt == WE_GREEN)  ? GREEN :
                       (state_nxt == WE_YELLOW) ? YELLOW : RED;
      police_Active <= (state_nxt == POLICE);
    end
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler: dwell lengths, ped calls,
// police override, reset and tick gating, with light-safety invariants.
module tb_intersection_phase_scheduler;
  import intersection_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n, tick;
  logic [3:0] traffic_Street_0, traffic_Street_1;
  logic       ped_Hori_Interrupt, ped_Vert_Interrupt, police_Interrupt;
  logic [1:0] north_South, west_East;
  logic       pedestrian_Hori_Street, pedestrian_Vert_Street;
  logic [3:0] phase;
  logic       police_Active;

  int errors = 0;
  int checks = 0;

  intersection_phase_scheduler dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .tick                   (tick),
    .traffic_Street_0       (traffic_Street_0),
    .traffic_Street_1       (traffic_Street_1),
    .ped_Hori_Interrupt     (ped_Hori_Interrupt),
    .ped_Vert_Interrupt     (ped_Vert_Interrupt),
    .police_Interrupt       (police_Interrupt),
    .north_South            (north_South),
    .west_East              (west_East),
    .pedestrian_Hori_Street (pedestrian_Hori_Street),
    .pedestrian_Vert_Street (pedestrian_Vert_Street),
    .phase                  (phase),
    .police_Active          (police_Active)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL global_timeout phase=%0d", phase);
    $fatal(1);
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (north_South != 2'b00 && west_East != 2'b00) begin
        errors++;
        $display("FAIL inv_both_lit ns=%b we=%b required one red", north_South, west_East);
      end
      if ((pedestrian_Hori_Street || pedestrian_Vert_Street) &&
          (north_South != 2'b00 || west_East != 2'b00)) begin
        errors++;
        $display("FAIL inv_walk_with_lit ns=%b we=%b walk=%b%b", north_South, west_East,
                 pedestrian_Hori_Street, pedestrian_Vert_Street);
      end
      if (north_South == 2'b11 || west_East == 2'b11) begin
        errors++;
        $display("FAIL inv_code11 ns=%b we=%b", north_South, west_East);
      end
    end
  endtask

  task automatic wait_change(output int n);
    logic [3:0] p0;
    p0 = phase;
    n  = 0;
    do begin
      step(1);
      n++;
    end while (phase == p0 && n < 200);
  endtask

  task automatic pulse_ped(input logic hori, input logic vert);
    ped_Hori_Interrupt = hori;
    ped_Vert_Interrupt = vert;
    step(1);
    ped_Hori_Interrupt = 1'b0;
    ped_Vert_Interrupt = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; tick = 1'b1;
    traffic_Street_0 = 4'd0; traffic_Street_1 = 4'd0;
    ped_Hori_Interrupt = 1'b0; ped_Vert_Interrupt = 1'b0; police_Interrupt = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    checks++;
    if (phase !== ALL_RED || north_South !== 2'b00 || west_East !== 2'b00 ||
        pedestrian_Hori_Street !== 1'b0 || pedestrian_Vert_Street !== 1'b0 || police_Active !== 1'b0) begin
      errors++;
      $display("FAIL reset_state phase=%0d ns=%b we=%b walk=%b%b pol=%b required 0/00/00/00/0",
               phase, north_South, west_East, pedestrian_Hori_Street, pedestrian_Vert_Street, police_Active);
    end
    wait_change(n);
    checks++;
    if (n !== 2 || phase !== NS_GREEN || north_South !== 2'b01 || west_East !== 2'b00) begin
      errors++;
      $display("FAIL first_all_red n=%0d phase=%0d ns=%b we=%b required n=2 NS_GREEN 01 00",
               n, phase, north_South, west_East);
    end
    step(40);
    checks++;
    if (phase !== NS_GREEN || north_South !== 2'b01) begin
      errors++;
      $display("FAIL idle_green_rest phase=%0d ns=%b required NS_GREEN 01", phase, north_South);
    end
  endtask

  task automatic test_demand_switch();
    int n;
    do_reset();
    traffic_Street_0 = 4'd2; traffic_Street_1 = 4'd5;
    wait_change(n);
    wait_change(n);
    checks++;
    if (n !== 8 || phase !== NS_YELLOW || north_South !== 2'b10) begin
      errors++;
      $display("FAIL demand_ns_green n=%0d phase=%0d ns=%b required 8 NS_YELLOW 10", n, phase, north_South);
    end
    wait_change(n);
    checks++;
    if (n !== 3 || phase !== ALL_RED) begin
      errors++;
      $display("FAIL demand_yellow n=%0d phase=%0d required 3 ALL_RED", n, phase);
    end
    wait_change(n);
    checks++;
    if (n !== 2 || phase !== WE_GREEN || west_East !== 2'b01 || north_South !== 2'b00) begin
      errors++;
      $display("FAIL demand_to_we n=%0d phase=%0d we=%b ns=%b required 2 WE_GREEN 01 00",
               n, phase, west_East, north_South);
    end
    wait_change(n);
    checks++;
    if (n !== 30 || phase !== WE_YELLOW) begin
      errors++;
      $display("FAIL demand_we_max n=%0d phase=%0d required 30 WE_YELLOW", n, phase);
    end
  endtask

  task automatic test_green_max();
    int n;
    do_reset();
    traffic_Street_0 = 4'd9; traffic_Street_1 = 4'd1;
    wait_change(n);
    wait_change(n);
    checks++;
    if (n !== 30 || phase !== NS_YELLOW) begin
      errors++;
      $display("FAIL green_max n=%0d phase=%0d required 30 NS_YELLOW", n, phase);
    end
  endtask

  task automatic test_ped_call();
    int n;
    do_reset();
    wait_change(n);
    step(2);
    pulse_ped(1'b1, 1'b0);
    wait_change(n);
    checks++;
    if (n + 3 !== 8 || phase !== NS_YELLOW) begin
      errors++;
      $display("FAIL ped_green_len n=%0d phase=%0d required 8 NS_YELLOW", n + 3, phase);
    end
    wait_change(n);
    wait_change(n);
    checks++;
    if (n !== 2 || phase !== PED_WALK || pedestrian_Hori_Street !== 1'b1 ||
        pedestrian_Vert_Street !== 1'b0 || north_South !== 2'b00 || west_East !== 2'b00) begin
      errors++;
      $display("FAIL ped_walk_entry n=%0d phase=%0d walk=%b%b ns=%b we=%b required 2 PED_WALK 10 00 00",
               n, phase, pedestrian_Hori_Street, pedestrian_Vert_Street, north_South, west_East);
    end
    wait_change(n);
    checks++;
    if (n !== 10 || phase !== ALL_RED || pedestrian_Hori_Street !== 1'b0) begin
      errors++;
      $display("FAIL ped_walk_len n=%0d phase=%0d hori=%b required 10 ALL_RED 0", n, phase, pedestrian_Hori_Street);
    end
    wait_change(n);
    checks++;
    if (n !== 2 || phase !== WE_GREEN) begin
      errors++;
      $display("FAIL ped_then_we n=%0d phase=%0d required 2 WE_GREEN", n, phase);
    end
    step(40);
    checks++;
    if (phase !== WE_GREEN) begin
      errors++;
      $display("FAIL ped_latch_cleared phase=%0d required WE_GREEN", phase);
    end
  endtask

  task automatic test_police();
    int n;
    do_reset();
    wait_change(n);
    pulse_ped(1'b0, 1'b1);
    wait_change(n);
    wait_change(n);
    wait_change(n);
    checks++;
    if (phase !== PED_WALK || pedestrian_Vert_Street !== 1'b1 || pedestrian_Hori_Street !== 1'b0) begin
      errors++;
      $display("FAIL police_setup_walk phase=%0d walk=%b%b required PED_WALK 01",
               phase, pedestrian_Hori_Street, pedestrian_Vert_Street);
    end
    step(4);
    police_Interrupt = 1'b1;
    step(1);
    checks++;
    if (phase !== POLICE || police_Active !== 1'b1 || north_South !== 2'b00 || west_East !== 2'b00 ||
        pedestrian_Hori_Street !== 1'b0 || pedestrian_Vert_Street !== 1'b0) begin
      errors++;
      $display("FAIL police_cut_walk phase=%0d pol=%b ns=%b we=%b walk=%b%b required POLICE 1 00 00 00",
               phase, police_Active, north_South, west_East, pedestrian_Hori_Street, pedestrian_Vert_Street);
    end
    step(19);
    checks++;
    if (phase !== POLICE || police_Active !== 1'b1) begin
      errors++;
      $display("FAIL police_hold phase=%0d pol=%b required POLICE 1", phase, police_Active);
    end
    police_Interrupt = 1'b0;
    step(1);
    checks++;
    if (phase !== ALL_RED || police_Active !== 1'b0) begin
      errors++;
      $display("FAIL police_release phase=%0d pol=%b required ALL_RED 0", phase, police_Active);
    end
    wait_change(n);
    checks++;
    if (n !== 2 || phase !== WE_GREEN) begin
      errors++;
      $display("FAIL police_resume n=%0d phase=%0d required 2 WE_GREEN", n, phase);
    end
    tick = 1'b0;
    police_Interrupt = 1'b1;
    step(1);
    checks++;
    if (phase !== WE_YELLOW || west_East !== 2'b10) begin
      errors++;
      $display("FAIL police_in_green phase=%0d we=%b required WE_YELLOW 10", phase, west_East);
    end
    tick = 1'b1;
    wait_change(n);
    checks++;
    if (n !== 3 || phase !== POLICE) begin
      errors++;
      $display("FAIL police_after_yellow n=%0d phase=%0d required 3 POLICE", n, phase);
    end
    pulse_ped(1'b1, 1'b0);
    police_Interrupt = 1'b0;
    step(1);
    wait_change(n);
    checks++;
    if (n !== 2 || phase !== PED_WALK || pedestrian_Hori_Street !== 1'b1) begin
      errors++;
      $display("FAIL police_ped_latched n=%0d phase=%0d hori=%b required 2 PED_WALK 1",
               n, phase, pedestrian_Hori_Street);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    wait_change(n);
    pulse_ped(1'b1, 1'b0);
    wait_change(n);
    wait_change(n);
    wait_change(n);
    step(9);
    ped_Vert_Interrupt = 1'b1;
    step(1);
    ped_Vert_Interrupt = 1'b0;
    checks++;
    if (phase !== ALL_RED) begin
      errors++;
      $display("FAIL b2b_walk_exit phase=%0d required ALL_RED", phase);
    end
    wait_change(n);
    checks++;
    if (n !== 2 || phase !== WE_GREEN) begin
      errors++;
      $display("FAIL b2b_green_first n=%0d phase=%0d required 2 WE_GREEN", n, phase);
    end
    wait_change(n);
    checks++;
    if (n !== 8 || phase !== WE_YELLOW) begin
      errors++;
      $display("FAIL b2b_green_len n=%0d phase=%0d required 8 WE_YELLOW", n, phase);
    end
    wait_change(n);
    wait_change(n);
    checks++;
    if (phase !== PED_WALK || pedestrian_Vert_Street !== 1'b1 || pedestrian_Hori_Street !== 1'b0) begin
      errors++;
      $display("FAIL b2b_served phase=%0d walk=%b%b required PED_WALK 01",
               phase, pedestrian_Hori_Street, pedestrian_Vert_Street);
    end
  endtask

  task automatic test_reset_tick_hold();
    int n;
    do_reset();
    traffic_Street_1 = 4'd5;
    wait_change(n);
    wait_change(n);
    wait_change(n);
    wait_change(n);
    pulse_ped(1'b1, 1'b0);
    wait_change(n);
    checks++;
    if (n + 1 !== 8 || phase !== WE_YELLOW) begin
      errors++;
      $display("FAIL rst_setup n=%0d phase=%0d required 8 WE_YELLOW", n + 1, phase);
    end
    step(1);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    checks++;
    if (phase !== ALL_RED || north_South !== 2'b00 || west_East !== 2'b00 || police_Active !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_yellow phase=%0d ns=%b we=%b pol=%b required ALL_RED 00 00 0",
               phase, north_South, west_East, police_Active);
    end
    tick = 1'b0;
    traffic_Street_1 = 4'd0;
    step(5);
    checks++;
    if (phase !== ALL_RED) begin
      errors++;
      $display("FAIL tick_hold_allred phase=%0d required ALL_RED", phase);
    end
    tick = 1'b1;
    wait_change(n);
    checks++;
    if (n !== 2 || phase !== NS_GREEN) begin
      errors++;
      $display("FAIL rst_latch_dir n=%0d phase=%0d required 2 NS_GREEN", n, phase);
    end
    tick = 1'b0;
    traffic_Street_1 = 4'd5;
    step(10);
    checks++;
    if (phase !== NS_GREEN) begin
      errors++;
      $display("FAIL tick_hold_green phase=%0d required NS_GREEN", phase);
    end
    tick = 1'b1;
    wait_change(n);
    checks++;
    if (n !== 8 || phase !== NS_YELLOW) begin
      errors++;
      $display("FAIL tick_hold_timer n=%0d phase=%0d required 8 NS_YELLOW", n, phase);
    end
  endtask

  initial begin
    test_reset();
    test_demand_switch();
    test_green_max();
    test_ped_call();
    test_police();
    test_back_to_back();
    test_reset_tick_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
Tick-driven phase scheduler for one four-way intersection. It grants the shared crossing to four requesters: the NS vehicle flow, the WE vehicle flow, latched pedestrian calls and a police override. It enforces minimum and maximum green, yellow and all-red clearance. Its outputs drive the existing Traffic_Light (2-bit) and Pedestrian_Light (1-bit) instances directly.

Parameters:
GREEN_MIN, 8, minimum vehicle green in ticks (>=1)
GREEN_MAX, 30, maximum green once the opposing direction has demand (>=GREEN_MIN)
YELLOW_TIME, 3, yellow dwell in ticks (>=1)
ALL_RED_TIME, 2, all-red clearance in ticks (>=1)
WALK_TIME, 10, pedestrian walk dwell in ticks (>=1)
TMR_W, 8, timer width; must hold max(all times)

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous, active-low reset
tick  in  1  one-cycle timebase strobe; timers advance only on tick
traffic_Street_0  in  4  NS queue count (unsigned)
traffic_Street_1  in  4  WE queue count (unsigned)
ped_Hori_Interrupt  in  1  pedestrian call pulse, horizontal-street crossings
ped_Vert_Interrupt  in  1  pedestrian call pulse, vertical-street crossings
police_Interrupt  in  1  level; all-red override while high
north_South  out  2  NS light code
west_East  out  2  WE light code
pedestrian_Hori_Street  out  1  1 = walk
pedestrian_Vert_Street  out  1  1 = walk
phase  out  4  current state encoding (debug/observability)
police_Active  out  1  high in POLICE state

Behaviour:
- Light code, shared package: 2'b00 red, 2'b01 green, 2'b10 yellow; 2'b11 is never driven.
- Moore outputs, decoded from the registered state. An output changes in the same cycle the state register updates.
- Reset (reset_n=0 at a clock edge) takes effect from any state:
  - state=ALL_RED, timer=0, next_dir=NS, ped latches=0
  - all vehicle codes 00, both walk=0, police_Active=0
- States: ALL_RED, NS_GREEN, NS_YELLOW, WE_GREEN, WE_YELLOW, PED_WALK, POLICE.
- Timer rules:
  - The timer clears on every state entry.
  - On a cycle with tick=1 and no transition, the timer increments.
  - A state with dwell N exits on the tick where timer==N-1, so it lasts exactly N ticks.
- Ped latches:
  - ped_hori_pend and ped_vert_pend set on the input pulse.
  - Both clear on entry to PED_WALK. The pedestrian inputs are also sampled in that entry cycle and keep the latch set, so a new call there is not lost.
  - A pending ped call is any latch set.
- X_GREEN (own count c_own, other count c_oth):
  - Exits to X_YELLOW on a tick where timer>=GREEN_MIN-1 and (ped pending, or c_oth>c_own).
  - Also exits on the tick where timer==GREEN_MAX-1 and (c_oth!=0 or ped pending).
  - With no demand it rests in green indefinitely; the timer saturates at GREEN_MAX-1.
- X_YELLOW: after YELLOW_TIME ticks goes to ALL_RED. next_dir toggles to the other direction on entry to ALL_RED from yellow.
- ALL_RED: after ALL_RED_TIME ticks:
  - goes to PED_WALK if ped pending and the previous state was not PED_WALK;
  - otherwise goes to next_dir GREEN.
- PED_WALK:
  - Both vehicle codes 00.
  - Walk output =1 for each crossing whose latch was set at entry (captured in grant regs).
  - After WALK_TIME ticks goes to ALL_RED.
- Police priority, evaluated every cycle regardless of tick:
  - In X_GREEN: go to X_YELLOW immediately. Yellow still lasts YELLOW_TIME.
  - In X_YELLOW: finish the yellow, then go to POLICE instead of ALL_RED. next_dir still toggles.
  - In ALL_RED or PED_WALK: go to POLICE next cycle. The walk is cut and the grants clear.
  - POLICE: all vehicle codes 00, walks 0. Held while police_Interrupt=1. On release goes to ALL_RED for the full ALL_RED_TIME, then follows the normal ALL_RED rules.
  - Ped calls arriving during POLICE stay latched.
- Simultaneous ped pulse and PED_WALK exit: the latch sets and is served at the next ALL_RED→PED_WALK opportunity, after one vehicle green.
- Never legal, and asserted in the bench:
  - both vehicle codes non-red;
  - any walk=1 with any vehicle code non-red.

Decomposition:
- Package intersection_pkg holds:
  - light code constants (RED/GREEN/YELLOW);
  - the phase state enum with explicit 4-bit encoding;
  - the direction constants NS/WE.
- One natural sub-module, phase_timer: a tick-gated counter with clear, saturate-at-limit and done=(timer==limit-1)&tick. It is instantiated once, with limit muxed by state.

Test Plan:
- Reset then tick every cycle, counts 0/0: ALL_RED for 2 ticks, then NS_GREEN held indefinitely; north_South=01, west_East=00.
- NS_GREEN with counts NS=2, WE=5: exits at tick 8 to NS_YELLOW for 3 ticks, ALL_RED for 2 ticks, then WE_GREEN.
- Counts NS=9, WE=1: NS green lasts exactly 30 ticks, then NS_YELLOW.
- ped_Hori pulse during NS_GREEN (counts 0/0) at tick 2: NS_GREEN ends at tick 8, yellow, all-red, PED_WALK for 10 ticks with hori walk=1 and vert walk=0, all-red, then WE_GREEN.
- police_Interrupt raised mid-PED_WALK: POLICE next cycle, all outputs red/0, police_Active=1. Released after 20 cycles: ALL_RED for 2 ticks, then next_dir green.
- reset_n low for one cycle during WE_YELLOW: next cycle state=ALL_RED, all lights red, latches cleared; tick=0 holds every state and timer unchanged.
